memoria_dados_param: RTL and testbench
======================================

// Module: memoria_dados_param
// PURPOSE
//  Parametrised data-memory stage for the MIPS datapath (MEM/WB boundary). Byte-addressed,
//  little-endian word RAM with byte/half/word loads and stores, sign/zero extension,
//  alignment and range checking, a configurable read pipeline and a post-reset clear
//  sequencer. Drives the write-back value (memory data or ALU result) to the register bank.
// PARAMETERS
//  DATA_W    32  word width; fixed lane logic requires 32.
//  DEPTH     64  number of words; power of two, >= 4.
//  ADDR_W    6   log2(DEPTH); word index = aluresult[ADDR_W+1:2].
//  READ_LAT  1   request-to-output latency in clk edges, 1..3.
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  en           in   1       request valid this cycle
//  memwrite     in   1       store request
//  memread      in   1       load request
//  memtoreg     in   1       1: write-back = memory data; 0: write-back = aluresult
//  tamanho      in   2       00 byte, 01 half, 10 word, 11 illegal
//  sem_sinal    in   1       1: zero-extend loads; 0: sign-extend
//  aluresult    in   DATA_W  byte address (or pass-through value when memtoreg=0)
//  valor2       in   DATA_W  store data, taken from low lanes (byte [7:0], half [15:0])
//  valorsalvar  out  DATA_W  write-back value
//  valid_out    out  1       valorsalvar/erro valid this cycle
//  erro         out  1       request faulted (qualified by valid_out)
//  ocupado      out  1       clear sequence in progress; requests ignored
// BEHAVIOUR
//  Reset (async): valorsalvar=0, valid_out=0, erro=0, ocupado=1, FSM->LIMPA, cnt=0,
//   all pipeline valids cleared. Reset mid-operation aborts in-flight requests (no output).
//  FSM LIMPA: each edge writes 0 to mem[cnt], cnt++; at cnt==DEPTH-1 write, go PRONTO.
//   ocupado=1 for exactly DEPTH edges after reset release; reset during LIMPA restarts at 0.
//  FSM PRONTO: ocupado=0; requests accepted when en=1. en while ocupado=1: dropped, no valid_out.
//  Accepted request, sampled at edge N; result appears at edge N+READ_LAT-1 with valid_out=1
//   for one cycle (READ_LAT=1: same edge, registered). Back-to-back requests every cycle.
//  Fault (erro=1, no write, valorsalvar=0) when memtoreg=1 or memwrite=1 and any of:
//   tamanho=11; half with addr[0]=1; word with addr[1:0]!=0; aluresult >= 4*DEPTH;
//   memread=1 and memwrite=1 together; memtoreg=1 with memread=0.
//  Store: write only the addressed lanes (byte lane addr[1:0], half lane addr[1]);
//   other lanes unchanged. Write commits at edge N regardless of READ_LAT.
//  Load: extract lane(s), extend per sem_sinal to DATA_W. Read-first: load and earlier
//   store same edge cannot coincide (one op/request); load at N+1 sees store from N.
//  memtoreg=0: valorsalvar=aluresult after READ_LAT, no memory access, no range check,
//   unless memwrite=1 (store performs normally; valorsalvar=aluresult).
//  valorsalvar holds its last value when valid_out=0; erro=0 when valid_out=0.
//  Memory contents unaffected by reset except through LIMPA sweep.
// TESTING
//  Reset, release: ocupado=1 for DEPTH cycles, then 0; load word @0x0 -> 0x00000000.
//  sw 0x8081_F27F @0x10; lb @0x10 -> 0x0000007F; lb @0x11 -> 0xFFFFFFF2;
//   lbu @0x12 -> 0x00000081; lh @0x12 -> 0xFFFF8081; lhu @0x12 -> 0x00008081.
//  sb 0xAB @0x21 over word 0x11223344 @0x20 -> lw @0x20 = 0x1122AB44.
//  Faults: lw @0x22, lh @0x23, lw @4*DEPTH, tamanho=11 -> erro=1, valorsalvar=0, no write.
//  READ_LAT=3: stream 8 lw + ALU pass-throughs (memtoreg=0, aluresult=0x1234) every cycle
//   -> outputs in order, 2 edges later each, valid_out continuous.
//  Reset asserted mid-LIMPA and mid-stream -> outputs zero immediately, sweep restarts.

Source files
------------

// File: rtl/memoria_dados_param.sv
// Data-memory stage at the MEM/WB boundary of the MIPS datapath.
// Byte-addressed little-endian word RAM with byte/half/word access,
// sign/zero extension, fault detection, a READ_LAT-deep result pipeline
// and a post-reset clear sweep that zeroes every word before requests are taken.
module memoria_dados_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic [1:0]        tamanho,
    input  logic              sem_sinal,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [DATA_W-1:0] valor2,
    output logic [DATA_W-1:0] valorsalvar,
    output logic              valid_out,
    output logic              erro,
    output logic              ocupado
);

    typedef enum logic {LIMPA, PRONTO} estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        lo;
    logic [ADDR_W-1:0] idx;
    logic              fora;
    logic              aceita;
    logic              falha;
    logic              grava;
    logic [DATA_W-1:0] palavra;
    logic [7:0]        byte_sel;
    logic [15:0]       meia_sel;
    logic [DATA_W-1:0] carga;
    logic [DATA_W-1:0] resultado;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;

    logic [READ_LAT-1:0] pv;
    logic [READ_LAT-1:0] pe;
    logic [DATA_W-1:0]   pd [READ_LAT];

    // Clear sequencer: sweep every word once after reset, then accept requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado  <= LIMPA;
            cnt     <= '0;
            ocupado <= 1'b1;
        end else begin
            case (estado)
                LIMPA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        estado  <= PRONTO;
                        ocupado <= 1'b0;
                    end
                end
                default: ocupado <= 1'b0;
            endcase
        end
    end

    // Request decode: address split, fault detection, lane extraction and extension.
    always_comb begin
        lo      = aluresult[1:0];
        idx     = aluresult[ADDR_W+1:2];
        fora    = |aluresult[DATA_W-1:ADDR_W+2];
        aceita  = en && (estado == PRONTO);
        falha   = (memtoreg || memwrite) &&
                  ((tamanho == 2'b11) ||
                   (tamanho == 2'b01 && lo[0]) ||
                   (tamanho == 2'b10 && lo != 2'b00) ||
                   fora ||
                   (memread && memwrite) ||
                   (memtoreg && !memread));
        grava    = aceita && memwrite && !falha;
        palavra  = mem[idx];
        byte_sel = palavra[{lo, 3'b000} +: 8];
        meia_sel = palavra[{lo[1], 4'b0000} +: 16];
        case (tamanho)
            2'b00:   carga = sem_sinal ? {{(DATA_W-8){1'b0}}, byte_sel}
                                       : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            2'b01:   carga = sem_sinal ? {{(DATA_W-16){1'b0}}, meia_sel}
                                       : {{(DATA_W-16){meia_sel[15]}}, meia_sel};
            default: carga = palavra;
        endcase
        if (falha)         resultado = '0;
        else if (memtoreg) resultado = carga;
        else               resultado = aluresult;
        case (tamanho)
            2'b00: begin
                wdata = {4{valor2[7:0]}};
                be    = 4'b0001 << lo;
            end
            2'b01: begin
                wdata = {2{valor2[15:0]}};
                be    = lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = valor2;
                be    = 4'b1111;
            end
        endcase
    end

    // Memory write port: clear sweep has priority, otherwise lane-masked stores.
    always_ff @(posedge clk) begin
        if (estado == LIMPA) begin
            mem[cnt] <= '0;
        end else if (grava) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Result pipeline; data stages only load on a valid so the output holds between results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
            pe <= '0;
            for (int unsigned k = 0; k < READ_LAT; k++) pd[k] <= '0;
        end else begin
            pv[0] <= aceita;
            pe[0] <= aceita && falha;
            if (aceita) pd[0] <= resultado;
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
                pe[k] <= pv[k-1] && pe[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end

    // Output taps from the last pipeline stage.
    always_comb begin
        valid_out   = pv[READ_LAT-1];
        erro        = pe[READ_LAT-1];
        valorsalvar = pd[READ_LAT-1];
    end

endmodule

// File: tb/tb_memoria_dados_param.sv
// Bench for memoria_dados_param: READ_LAT=1 and READ_LAT=3 instances share
// stimulus; each has its own queue of expected results tagged with due cycle.
module tb_memoria_dados_param;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, memwrite, memread, memtoreg, sem_sinal;
    logic [1:0]  tamanho;
    logic [31:0] aluresult, valor2;
    logic [31:0] vs1, vs3;
    logic        v1, v3, e1, e3, o1, o3;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    item_t q1[$];
    item_t q3[$];
    bit    exp1, exp3;
    item_t it1, it3;

    memoria_dados_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(6), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .memwrite(memwrite), .memread(memread),
        .memtoreg(memtoreg), .tamanho(tamanho), .sem_sinal(sem_sinal),
        .aluresult(aluresult), .valor2(valor2), .valorsalvar(vs1),
        .valid_out(v1), .erro(e1), .ocupado(o1));

    memoria_dados_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(6), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .memwrite(memwrite), .memread(memread),
        .memtoreg(memtoreg), .tamanho(tamanho), .sem_sinal(sem_sinal),
        .aluresult(aluresult), .valor2(valor2), .valorsalvar(vs3),
        .valid_out(v3), .erro(e3), .ocupado(o3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Output monitors: compare against queue front when it falls due.
    always @(negedge clk) begin
        exp1 = (q1.size() > 0) && (q1[0].due == cyc);
        chk1("valid_l1", v1, exp1);
        if (exp1) begin
            it1 = q1.pop_front();
            chk32("data_l1", vs1, it1.data);
            chk1("erro_l1", e1, it1.err);
        end else begin
            chk1("erro_idle_l1", e1, 1'b0);
        end
    end

    always @(negedge clk) begin
        exp3 = (q3.size() > 0) && (q3[0].due == cyc);
        chk1("valid_l3", v3, exp3);
        if (exp3) begin
            it3 = q3.pop_front();
            chk32("data_l3", vs3, it3.data);
            chk1("erro_l3", e3, it3.err);
        end else begin
            chk1("erro_idle_l3", e3, 1'b0);
        end
    end

    task automatic req(input logic mw, input logic mr, input logic mt, input logic [1:0] tam,
                       input logic ss, input logic [31:0] a, input logic [31:0] v2,
                       input logic [31:0] ed, input logic ee);
        en = 1'b1; memwrite = mw; memread = mr; memtoreg = mt;
        tamanho = tam; sem_sinal = ss; aluresult = a; valor2 = v2;
        q1.push_back('{data: ed, err: ee, due: cyc + 1});
        q3.push_back('{data: ed, err: ee, due: cyc + 3});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0; memwrite = 1'b0; memread = 1'b0; memtoreg = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] ed);
        req(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, a, 32'h0, ed, 1'b0);
    endtask

    task automatic ld(input logic [1:0] tam, input logic ss, input logic [31:0] a, input logic [31:0] ed);
        req(1'b0, 1'b1, 1'b1, tam, ss, a, 32'h0, ed, 1'b0);
    endtask

    task automatic st(input logic [1:0] tam, input logic [31:0] a, input logic [31:0] v);
        req(1'b1, 1'b0, 1'b0, tam, 1'b0, a, v, a, 1'b0);
    endtask

    task automatic ldfault(input logic [1:0] tam, input logic [31:0] a);
        req(1'b0, 1'b1, 1'b1, tam, 1'b0, a, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic pt(input logic [31:0] a);
        req(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, a, 32'h0, a, 1'b0);
    endtask

    task automatic count_sweep;
        int n1 = 0;
        int n3 = 0;
        int g  = 0;
        while ((o1 || o3) && g < 4 * DEPTH) begin
            if (o1) n1++;
            if (o3) n3++;
            g++;
            @(posedge clk); #1;
        end
        chk32("sweep_len_l1", n1, DEPTH);
        chk32("sweep_len_l3", n3, DEPTH);
    endtask

    task automatic chk_reset_outputs;
        chk32("rst_vs_l1", vs1, 32'h0);
        chk32("rst_vs_l3", vs3, 32'h0);
        chk1("rst_valid_l1", v1, 1'b0);
        chk1("rst_valid_l3", v3, 1'b0);
        chk1("rst_erro_l1", e1, 1'b0);
        chk1("rst_erro_l3", e3, 1'b0);
        chk1("rst_ocup_l1", o1, 1'b1);
        chk1("rst_ocup_l3", o3, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b0; memwrite = 1'b0; memread = 1'b0; memtoreg = 1'b0;
        tamanho = 2'b10; sem_sinal = 1'b0; aluresult = '0; valor2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();

        // Release; requests during the sweep must be dropped.
        reset = 1'b0;
        en = 1'b1; memread = 1'b1; memtoreg = 1'b1; tamanho = 2'b10; aluresult = 32'h0;
        count_sweep();
        en = 1'b0;
        idle(1);
        lw(32'h0, 32'h0);

        // Store word then sub-word loads with extension.
        st(2'b10, 32'h10, 32'h8081_F27F);
        ld(2'b00, 1'b0, 32'h10, 32'h0000_007F);
        ld(2'b00, 1'b0, 32'h11, 32'hFFFF_FFF2);
        ld(2'b00, 1'b1, 32'h12, 32'h0000_0081);
        ld(2'b01, 1'b0, 32'h12, 32'hFFFF_8081);
        ld(2'b01, 1'b1, 32'h12, 32'h0000_8081);
        ld(2'b10, 1'b0, 32'h10, 32'h8081_F27F);

        // Byte store merges into existing word.
        st(2'b10, 32'h20, 32'h1122_3344);
        st(2'b00, 32'h21, 32'hFFFF_FFAB);
        lw(32'h20, 32'h1122_AB44);

        // Faults.
        ldfault(2'b10, 32'h22);
        ldfault(2'b01, 32'h23);
        ldfault(2'b10, 32'h0000_0100);
        ldfault(2'b11, 32'h20);
        req(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        lw(32'h20, 32'h1122_AB44);
        st(2'b01, 32'h22, 32'hFFFF_5566);
        lw(32'h20, 32'h5566_AB44);

        // Address boundary and pass-through without range check.
        lw(32'hFC, 32'h0);
        st(2'b10, 32'hFC, 32'hCAFE_F00D);
        lw(32'hFC, 32'hCAFE_F00D);
        pt(32'hFFFF_FFF0);
        idle(4);

        // Store then load on the very next cycle, then fill stream words.
        for (int i = 0; i < 8; i++) begin
            st(2'b10, 32'h40 + 32'(4 * i), 32'hA0B0_C000 + 32'(i));
            lw(32'h40 + 32'(4 * i), 32'hA0B0_C000 + 32'(i));
        end
        idle(4);

        // Back-to-back stream of loads and ALU pass-throughs.
        for (int i = 0; i < 8; i++) begin
            lw(32'h40 + 32'(4 * i), 32'hA0B0_C000 + 32'(i));
            pt(32'h0000_1234);
        end
        idle(5);

        // Reset in the middle of a stream: in-flight results are discarded.
        for (int i = 0; i < 4; i++) pt(32'h0000_0100 + 32'(i));
        reset = 1'b1; en = 1'b0;
        q1.delete(); q3.delete();
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        count_sweep();
        lw(32'h10, 32'h0);
        lw(32'h20, 32'h0);
        lw(32'hFC, 32'h0);
        idle(6);

        chk32("queue_empty_l1", q1.size(), 32'd0);
        chk32("queue_empty_l3", q3.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
